// File: rtl/cpu_pkg.sv
// Shared control-unit definitions: fetch FSM encoding, IR field positions, opcodes.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FETCH = 2'b01,
        HOLD  = 2'b10
    } fetch_state_e;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 27;
    localparam int DST_MSB = 26;
    localparam int DST_LSB = 23;
    localparam int RA_MSB  = 22;
    localparam int RA_LSB  = 19;
    localparam int RB_MSB  = 18;
    localparam int RB_LSB  = 15;

    localparam logic [4:0] OP_MUL = 5'b01100;
    localparam logic [4:0] OP_DIV = 5'b01101;

    function automatic logic [4:0] ir_opcode(input logic [31:0] w);
        return w[OPC_MSB:OPC_LSB];
    endfunction

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: req/ack memory fetch into ir, valid/ready hand-off to decode,
// branch redirect and sticky timeout detection for memory that never acknowledges.
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_INC   = 32'd1,
    parameter int          TIMEOUT  = 15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        en,
    output logic [31:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [31:0] mem_data,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ir,
    output logic        ir_valid,
    input  logic        ir_ready,
    output logic [31:0] pc,
    output logic        fetch_err
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    fetch_state_e state, state_nxt;
    logic [7:0]   wait_cnt;
    logic         ack_take;
    logic         timeout_hit;

    assign ack_take    = (state == FETCH) && mem_ack;
    assign timeout_hit = (state == FETCH) && !mem_ack && (wait_cnt == WAIT_LAST);

    // Request is a pure function of state so an async reset drops it at once.
    assign mem_rd = (state == FETCH);

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (en && !fetch_err) state_nxt = FETCH;
            FETCH:   begin
                if (mem_ack)          state_nxt = HOLD;
                else if (timeout_hit) state_nxt = IDLE;
            end
            HOLD:    if (ir_ready) state_nxt = en ? FETCH : IDLE;
            default: state_nxt = IDLE;
        endcase
        if (redirect) state_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            mem_addr  <= RESET_PC;
            ir        <= '0;
            ir_valid  <= 1'b0;
            pc        <= '0;
            fetch_err <= 1'b0;
            wait_cnt  <= '0;
        end else if (redirect) begin
            // A same-cycle ack or consume is dropped; ir/pc keep the old word.
            mem_addr  <= redirect_pc;
            ir_valid  <= 1'b0;
            fetch_err <= 1'b0;
            wait_cnt  <= '0;
        end else begin
            if (state_nxt == FETCH && state != FETCH)
                wait_cnt <= '0;
            if (ack_take) begin
                ir       <= mem_data;
                pc       <= mem_addr;
                mem_addr <= mem_addr + PC_INC;
                ir_valid <= 1'b1;
                wait_cnt <= '0;
            end else if (timeout_hit) begin
                fetch_err <= 1'b1;
            end else if (state == FETCH) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (state == HOLD && ir_ready)
                ir_valid <= 1'b0;
        end
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream stage of the control unit: fetches 32-bit instruction words from instruction memory over a request/acknowledge handshake.
- Holds each fetched word in an instruction register (ir) and presents it with a valid/ready handshake.
- The control unit decodes ir as opcode [31:27], dest [26:23], srcA [22:19], srcB [18:15].
- Maintains the fetch program counter, accepts branch redirects, and flags memory that never acknowledges.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address loaded on reset.
- PC_INC, 1, address increment per instruction (word-addressed memory).
- TIMEOUT, 15, cycles to wait for mem_ack before declaring a fetch error (range 1..255).

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-low reset.
- en  in  1  fetch enable; low stops new fetches but does not abort an outstanding one.
- mem_addr  out  32  instruction memory address.
- mem_rd  out  1  read request; held high until mem_ack.
- mem_ack  in  1  memory acknowledge; mem_data valid in the same cycle.
- mem_data  in  32  instruction word from memory.
- redirect  in  1  one-cycle branch/jump request.
- redirect_pc  in  32  target address, sampled when redirect=1.
- ir  out  32  current instruction word.
- ir_valid  out  1  ir holds an unconsumed instruction.
- ir_ready  in  1  control unit consumes ir this cycle (drives its write enable).
- pc  out  32  address from which ir was fetched.
- fetch_err  out  1  sticky timeout flag.

Behaviour:
Reset (clr=0, asynchronous):
- state=IDLE, mem_addr=RESET_PC, mem_rd=0, ir=0, ir_valid=0, pc=0, fetch_err=0, wait counter=0.

States and transitions:
- IDLE:
  - If en=1 and fetch_err=0, go to FETCH next cycle.
- FETCH:
  - mem_rd=1 with mem_addr stable.
  - On mem_ack: ir<=mem_data, pc<=mem_addr, mem_addr<=mem_addr+PC_INC, ir_valid<=1, mem_rd<=0, go to HOLD.
  - Otherwise increment the wait counter. When it reaches TIMEOUT with no ack: fetch_err<=1, mem_rd<=0, go to IDLE.
- HOLD:
  - ir_valid=1; ir and pc held stable.
  - When ir_ready=1: ir_valid<=0, then go to FETCH if en=1, else IDLE.
  - ir_ready while ir_valid=0 is ignored.

Latency and throughput:
- ack in the first FETCH cycle gives ir_valid one cycle after that ack, i.e. 2 cycles from leaving IDLE.
- Best-case throughput is one instruction per 2 cycles (FETCH, HOLD).

Wait counter:
- Cleared on entry to FETCH and on every ack.

Address arithmetic:
- mem_addr wraps modulo 2^32: 32'hFFFF_FFFF + 1 = 0. No carry out.

Redirect (any state, highest priority after reset):
- mem_addr<=redirect_pc, ir_valid<=0, fetch_err<=0, wait counter<=0.
- mem_rd is low the cycle after redirect. State goes to IDLE, so fetching resumes from redirect_pc one cycle later if en=1.
- A mem_ack in the same cycle as redirect is discarded: ir and pc unchanged.
- ir_ready in the same cycle as redirect has no further effect.

Other boundary cases:
- en dropping during FETCH: the fetch completes normally; HOLD then goes to IDLE.
- fetch_err=1: stays in IDLE regardless of en until redirect or reset.
- Reset mid-FETCH: mem_rd drops immediately (asynchronous); the memory must tolerate an abandoned request.

Decomposition:
- Shared package (cpu_pkg):
  - state encoding IDLE=2'b00, FETCH=2'b01, HOLD=2'b10.
  - IR field constants OPC_MSB=31, OPC_LSB=27, DST_MSB=26, DST_LSB=23, RA_MSB=22, RA_LSB=19, RB_MSB=18, RB_LSB=15.
  - opcode constants OP_MUL=5'b01100, OP_DIV=5'b01101.
- No sub-module. The FSM, counter and registers form one module; the wait counter is too small to split out.

Test Plan:
- Reset release with en=1, memory acks in 1 cycle with 32'h1111_0000 at addr 0 → mem_rd high, mem_addr=0; next cycle ir=32'h1111_0000, pc=0, ir_valid=1, mem_addr=1.
- Hold ir_ready=0 for 5 cycles → ir, pc, ir_valid stable and mem_rd=0 throughout; ir_ready=1 → ir_valid=0 next cycle and fetch from addr 1 starts.
- Memory never acks, TIMEOUT=15 → fetch_err=1 after 15 FETCH cycles, mem_rd=0, stays IDLE with en=1; redirect to 32'h40 → fetch_err=0 and fetch resumes at 32'h40.
- redirect to 32'h0000_0100 in the same cycle as mem_ack with 32'hDEAD_BEEF → ir unchanged, ir_valid=0, next fetch at 32'h100.
- Start at RESET_PC=32'hFFFF_FFFF, one ack → pc=32'hFFFF_FFFF, mem_addr=32'h0000_0000.
- Assert clr low mid-FETCH → mem_rd, ir_valid and fetch_err are 0 immediately, before the next clk edge; mem_addr=RESET_PC.
